// File: rtl/m_ai_move_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : m_ai_move_scheduler_pkg
//  Brief    : Board geometry, FSM states and column helpers for the CPU turn
//             scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package m_ai_move_scheduler_pkg;

    localparam int ROWS       = 6;
    localparam int NUM_COLS   = 7;
    localparam int PILE_W     = 3;
    localparam int COL_SIZE   = 3;
    localparam int FIELD_SIZE = ROWS * NUM_COLS;
    localparam int PCA_SIZE   = PILE_W * NUM_COLS;

    typedef enum logic [2:0] {
        ST_COOLDOWN = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SEARCH   = 3'd2,
        ST_APPLY    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Height lookup that never slices past the array for col >= NUM_COLS.
    function automatic logic [PILE_W-1:0] height_of(input logic [PCA_SIZE-1:0] pca,
                                                    input logic [COL_SIZE-1:0] col);
        height_of = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (int'(col) == c) height_of = pca[c*PILE_W +: PILE_W];
        end
    endfunction

    function automatic logic col_is_legal(input logic [PCA_SIZE-1:0] pca,
                                          input logic [COL_SIZE-1:0] col);
        col_is_legal = (int'(col) < NUM_COLS) && (int'(height_of(pca, col)) < ROWS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_ai_move_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : m_ai_move_scheduler_if
//  Brief    : Turn request/result bus plus search-engine handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface m_ai_move_scheduler_if;
    import m_ai_move_scheduler_pkg::*;

    logic                    req;
    logic [FIELD_SIZE-1:0]   me_field;
    logic [FIELD_SIZE-1:0]   op_field;
    logic [PCA_SIZE-1:0]     pile_count_array;
    logic                    busy;
    logic                    done;
    logic [COL_SIZE-1:0]     col;
    logic signed [15:0]      score;
    logic [FIELD_SIZE-1:0]   me_field_out;
    logic [PCA_SIZE-1:0]     pile_count_array_out;
    logic                    timeout;
    logic                    no_move;
    logic                    search_en;
    logic [FIELD_SIZE-1:0]   search_me_field;
    logic [FIELD_SIZE-1:0]   search_op_field;
    logic [PCA_SIZE-1:0]     search_pile_count_array;
    logic                    search_fin;
    logic signed [15:0]      search_score;
    logic [COL_SIZE-1:0]     search_col;

    modport slave (
        input  req, me_field, op_field, pile_count_array,
               search_fin, search_score, search_col,
        output busy, done, col, score, me_field_out, pile_count_array_out,
               timeout, no_move, search_en,
               search_me_field, search_op_field, search_pile_count_array
    );

    modport master (
        output req, me_field, op_field, pile_count_array,
               search_fin, search_score, search_col,
        input  busy, done, col, score, me_field_out, pile_count_array_out,
               timeout, no_move, search_en,
               search_me_field, search_op_field, search_pile_count_array
    );

endinterface
`default_nettype wire

// File: rtl/m_ai_move_scheduler_first_legal_col.sv
`default_nettype none
// ============================================================================
//  Module   : m_ai_move_scheduler_first_legal_col
//  Brief    : Lowest-index column that still has room; any=0 when board full.
//  Revision : 1.0  initial release
// ============================================================================
module m_ai_move_scheduler_first_legal_col
    import m_ai_move_scheduler_pkg::*;
(
    input  logic [PCA_SIZE-1:0] pca,
    output logic                any,
    output logic [COL_SIZE-1:0] col
);

    // Scan high to low so the last hit is the lowest index.
    always_comb begin
        any = 1'b0;
        col = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (int'(pca[c*PILE_W +: PILE_W]) < ROWS) begin
                any = 1'b1;
                col = COL_SIZE'(c);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/m_ai_move_scheduler_piler.sv
`default_nettype none
// ============================================================================
//  Module   : m_ai_move_scheduler_piler
//  Brief    : Drops one stone into a column; passes inputs through when illegal.
//  Revision : 1.0  initial release
// ============================================================================
module m_ai_move_scheduler_piler
    import m_ai_move_scheduler_pkg::*;
(
    input  logic [FIELD_SIZE-1:0] field,
    input  logic [PCA_SIZE-1:0]   pca,
    input  logic [COL_SIZE-1:0]   col,
    output logic                  valid,
    output logic [FIELD_SIZE-1:0] field_out,
    output logic [PCA_SIZE-1:0]   pca_out
);

    always_comb begin
        valid     = col_is_legal(pca, col);
        field_out = field;
        pca_out   = pca;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (valid && (int'(col) == c)) begin
                pca_out[c*PILE_W +: PILE_W] = pca[c*PILE_W +: PILE_W] + PILE_W'(1);
                for (int r = 0; r < ROWS; r++) begin
                    if (int'(pca[c*PILE_W +: PILE_W]) == r) field_out[c*ROWS + r] = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/m_ai_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : m_ai_move_scheduler
//  Brief    : Runs one CPU turn: latch board, drive search engine, apply move.
//  Revision : 1.0  initial release
// ============================================================================
module m_ai_move_scheduler
    import m_ai_move_scheduler_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES  = 24'd10_000_000,
    parameter int          COOLDOWN_CYCLES = 4
)(
    input  logic               clk,
    input  logic               rst,
    m_ai_move_scheduler_if.slave bus
);

    localparam logic [7:0] c_cd_load = 8'(COOLDOWN_CYCLES);

    state_t                r_state;
    state_t                w_next_state;
    logic [7:0]            r_cd_cnt;
    logic [23:0]           r_tcnt;
    logic                  r_post_reset;
    logic [FIELD_SIZE-1:0] r_me;
    logic [FIELD_SIZE-1:0] r_op;
    logic [PCA_SIZE-1:0]   r_pca;
    logic [COL_SIZE-1:0]   r_res_col;
    logic signed [15:0]    r_res_score;
    logic                  r_res_timeout;
    logic [COL_SIZE-1:0]   r_col;
    logic signed [15:0]    r_score;
    logic [FIELD_SIZE-1:0] r_me_out;
    logic [PCA_SIZE-1:0]   r_pca_out;
    logic                  r_timeout;
    logic                  r_no_move;

    logic                  w_busy;
    logic                  w_done;
    logic                  w_search_en;
    logic [PCA_SIZE-1:0]   w_flc_pca;
    logic                  w_any;
    logic [COL_SIZE-1:0]   w_fb_col;
    logic                  w_timeout_hit;
    logic                  w_res_legal;
    logic [COL_SIZE-1:0]   w_apply_col;
    logic                  w_pil_valid;
    logic [FIELD_SIZE-1:0] w_pil_field;
    logic [PCA_SIZE-1:0]   w_pil_pca;

    // In IDLE the legality check looks at the incoming board; afterwards at the latched one.
    assign w_flc_pca     = (r_state == ST_IDLE) ? bus.pile_count_array : r_pca;
    assign w_timeout_hit = (TIMEOUT_CYCLES != 24'd0) && (r_tcnt == TIMEOUT_CYCLES - 24'd1);
    assign w_res_legal   = col_is_legal(r_pca, r_res_col);
    assign w_apply_col   = w_res_legal ? r_res_col : w_fb_col;

    m_ai_move_scheduler_first_legal_col u_first_legal_col (
        .pca (w_flc_pca),
        .any (w_any),
        .col (w_fb_col)
    );

    m_ai_move_scheduler_piler u_piler (
        .field     (r_me),
        .pca       (r_pca),
        .col       (w_apply_col),
        .valid     (w_pil_valid),
        .field_out (w_pil_field),
        .pca_out   (w_pil_pca)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_COOLDOWN;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_search_en  = 1'b0;
        unique case (r_state)
            ST_COOLDOWN: begin
                w_busy = ~r_post_reset;
                if (r_cd_cnt <= 8'd1) w_next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.req) w_next_state = w_any ? ST_SEARCH : ST_APPLY;
            end
            ST_SEARCH: begin
                w_busy      = 1'b1;
                w_search_en = 1'b1;
                if (bus.search_fin || w_timeout_hit) w_next_state = ST_APPLY;
            end
            ST_APPLY: begin
                w_busy       = 1'b1;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_next_state = ST_COOLDOWN;
            end
            default: w_next_state = ST_COOLDOWN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cd_cnt      <= c_cd_load;
            r_tcnt        <= '0;
            r_post_reset  <= 1'b1;
            r_me          <= '0;
            r_op          <= '0;
            r_pca         <= '0;
            r_res_col     <= '0;
            r_res_score   <= '0;
            r_res_timeout <= 1'b0;
            r_col         <= '0;
            r_score       <= '0;
            r_me_out      <= '0;
            r_pca_out     <= '0;
            r_timeout     <= 1'b0;
            r_no_move     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_COOLDOWN: begin
                    if (r_cd_cnt != 8'd0) r_cd_cnt <= r_cd_cnt - 8'd1;
                end
                ST_IDLE: begin
                    r_post_reset <= 1'b0;
                    if (bus.req) begin
                        r_me          <= bus.me_field;
                        r_op          <= bus.op_field;
                        r_pca         <= bus.pile_count_array;
                        r_tcnt        <= '0;
                        r_res_col     <= '0;
                        r_res_score   <= '0;
                        r_res_timeout <= 1'b0;
                    end
                end
                ST_SEARCH: begin
                    if (bus.search_fin) begin
                        r_res_col     <= bus.search_col;
                        r_res_score   <= bus.search_score;
                        r_res_timeout <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_res_col     <= w_fb_col;
                        r_res_score   <= '0;
                        r_res_timeout <= 1'b1;
                    end else if (r_tcnt != 24'hFF_FFFF) begin
                        r_tcnt <= r_tcnt + 24'd1;
                    end
                end
                ST_APPLY: begin
                    // An invalid piler result here means the board was full on entry.
                    r_col     <= w_pil_valid ? w_apply_col : '0;
                    r_score   <= (w_pil_valid && w_res_legal) ? r_res_score : 16'sd0;
                    r_me_out  <= w_pil_field;
                    r_pca_out <= w_pil_pca;
                    r_timeout <= r_res_timeout;
                    r_no_move <= ~w_pil_valid;
                end
                ST_DONE: begin
                    r_cd_cnt <= c_cd_load;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy                    = w_busy;
    assign bus.done                    = w_done;
    assign bus.search_en               = w_search_en;
    assign bus.col                     = r_col;
    assign bus.score                   = r_score;
    assign bus.me_field_out            = r_me_out;
    assign bus.pile_count_array_out    = r_pca_out;
    assign bus.timeout                 = r_timeout;
    assign bus.no_move                 = r_no_move;
    assign bus.search_me_field         = r_me;
    assign bus.search_op_field         = r_op;
    assign bus.search_pile_count_array = r_pca;

endmodule
`default_nettype wire

// File: tb/tb_m_ai_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_ai_move_scheduler
//  Brief    : Directed bench for the CPU turn scheduler with a scripted engine.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m_ai_move_scheduler;
    import m_ai_move_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    m_ai_move_scheduler_if bus();

    m_ai_move_scheduler #(
        .TIMEOUT_CYCLES  (24'd100),
        .COOLDOWN_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [PCA_SIZE-1:0] pca_one(input int c, input int h);
        pca_one = '0;
        pca_one[c*PILE_W +: PILE_W] = PILE_W'(h);
    endfunction

    function automatic logic [FIELD_SIZE-1:0] fbit(input int c, input int r);
        fbit = '0;
        fbit[c*ROWS + r] = 1'b1;
    endfunction

    task automatic start_turn(input logic [FIELD_SIZE-1:0] me, input logic [FIELD_SIZE-1:0] op,
                              input logic [PCA_SIZE-1:0] pca);
        bus.me_field         = me;
        bus.op_field         = op;
        bus.pile_count_array = pca;
        bus.req              = 1'b1;
        tick();
        bus.req              = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({bus.busy, bus.done, bus.search_en, bus.timeout, bus.no_move} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000", {bus.busy, bus.done, bus.search_en, bus.timeout, bus.no_move});
        end
        n_cmp++;
        if ({bus.col, bus.score, bus.me_field_out, bus.pile_count_array_out, bus.search_me_field} !== '0) begin
            n_bad++; $display("FAIL reset_data: got nonzero result/search registers, want all zero");
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({bus.busy, bus.search_en} !== 2'b00) begin
            n_bad++; $display("FAIL reset_cooldown_busy: got busy/en %b want 00", {bus.busy, bus.search_en});
        end
        repeat (5) tick();
    endtask

    task automatic test_normal();
        start_turn('0, '0, '0);
        n_cmp++;
        if ({bus.search_en, bus.busy} !== 2'b11) begin
            n_bad++; $display("FAIL normal_en_rise: got en/busy %b want 11", {bus.search_en, bus.busy});
        end
        repeat (49) tick();
        bus.search_fin = 1'b1; bus.search_col = 3'd3; bus.search_score = 16'sd12;
        tick();
        bus.search_fin = 1'b0;
        n_cmp++;
        if ({bus.search_en, bus.done} !== 2'b00) begin
            n_bad++; $display("FAIL normal_en_drop: got en/done %b want 00", {bus.search_en, bus.done});
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.col !== 3'd3 || bus.score !== 16'sd12 || bus.timeout !== 1'b0) begin
            n_bad++; $display("FAIL normal_result: got done=%b col=%0d score=%0d to=%b want 1 3 12 0",
                              bus.done, bus.col, bus.score, bus.timeout);
        end
        n_cmp++;
        if (bus.me_field_out !== fbit(3, 0) || bus.pile_count_array_out !== pca_one(3, 1)) begin
            n_bad++; $display("FAIL normal_board: got me=%h pca=%h want %h %h",
                              bus.me_field_out, bus.pile_count_array_out, fbit(3, 0), pca_one(3, 1));
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL normal_done_pulse: got done/busy %b%b want 01", bus.done, bus.busy);
        end
        repeat (3) tick();
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL normal_cooldown_len: got busy %b want 1", bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL normal_back_idle: got busy %b want 0", bus.busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [PCA_SIZE-1:0] pca;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL timeout_idle_wait: got busy want idle"); end
        pca = pca_one(0, 6) | pca_one(1, 2);
        start_turn(42'h3F, 42'hC0, pca);
        repeat (99) tick();
        n_cmp++;
        if ({bus.search_en, bus.done} !== 2'b10) begin
            n_bad++; $display("FAIL timeout_budget: got en/done %b want 10", {bus.search_en, bus.done});
        end
        tick();
        n_cmp++;
        if ({bus.search_en, bus.done} !== 2'b00) begin
            n_bad++; $display("FAIL timeout_en_drop: got en/done %b want 00", {bus.search_en, bus.done});
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.timeout !== 1'b1 || bus.col !== 3'd1 || bus.score !== 16'sd0) begin
            n_bad++; $display("FAIL timeout_result: got done=%b to=%b col=%0d score=%0d want 1 1 1 0",
                              bus.done, bus.timeout, bus.col, bus.score);
        end
        n_cmp++;
        if (bus.pile_count_array_out !== (pca_one(0, 6) | pca_one(1, 3)) || bus.me_field_out !== 42'h13F) begin
            n_bad++; $display("FAIL timeout_board: got me=%h pca=%h want 13f %h",
                              bus.me_field_out, bus.pile_count_array_out, pca_one(0, 6) | pca_one(1, 3));
        end
    endtask

    task automatic test_fin_timeout_tie();
        bit ok;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL tie_idle_wait: got busy want idle"); end
        start_turn('0, '0, '0);
        repeat (99) tick();
        bus.search_fin = 1'b1; bus.search_col = 3'd5; bus.search_score = 16'sd7;
        tick();
        bus.search_fin = 1'b0;
        tick();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.timeout !== 1'b0 || bus.col !== 3'd5 || bus.score !== 16'sd7) begin
            n_bad++; $display("FAIL tie_fin_wins: got done=%b to=%b col=%0d score=%0d want 1 0 5 7",
                              bus.done, bus.timeout, bus.col, bus.score);
        end
    endtask

    task automatic test_no_move();
        bit ok;
        int en_seen = 0;
        logic [FIELD_SIZE-1:0] me;
        logic [PCA_SIZE-1:0]   pca;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL nomove_idle_wait: got busy want idle"); end
        me  = '0;
        pca = '0;
        for (int i = 0; i < FIELD_SIZE; i += 2) me[i] = 1'b1;
        for (int c = 0; c < NUM_COLS; c++) pca |= pca_one(c, 6);
        start_turn(me, ~me, pca);
        if (bus.search_en) en_seen++;
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            n_bad++; $display("FAIL nomove_busy: got busy/done %b want 10", {bus.busy, bus.done});
        end
        tick();
        if (bus.search_en) en_seen++;
        n_cmp++;
        if (bus.done !== 1'b1 || bus.no_move !== 1'b1 || bus.col !== 3'd0 || bus.score !== 16'sd0 || bus.timeout !== 1'b0) begin
            n_bad++; $display("FAIL nomove_flags: got done=%b nm=%b col=%0d score=%0d to=%b want 1 1 0 0 0",
                              bus.done, bus.no_move, bus.col, bus.score, bus.timeout);
        end
        n_cmp++;
        if (bus.me_field_out !== me || bus.pile_count_array_out !== pca) begin
            n_bad++; $display("FAIL nomove_unchanged: got me=%h pca=%h want %h %h",
                              bus.me_field_out, bus.pile_count_array_out, me, pca);
        end
        repeat (6) begin tick(); if (bus.search_en) en_seen++; end
        n_cmp++;
        if (en_seen !== 0) begin
            n_bad++; $display("FAIL nomove_en_quiet: got %0d en cycles want 0", en_seen);
        end
    endtask

    task automatic test_illegal_col();
        bit ok;
        logic [PCA_SIZE-1:0] pca;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL illegal_idle_wait: got busy want idle"); end
        pca = pca_one(0, 6) | pca_one(1, 6);
        start_turn(42'hFFF, '0, pca);
        repeat (4) tick();
        bus.search_fin = 1'b1; bus.search_col = 3'd7; bus.search_score = -16'sd5;
        tick();
        bus.search_fin = 1'b0;
        tick();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.col !== 3'd2 || bus.score !== 16'sd0 || bus.timeout !== 1'b0 || bus.no_move !== 1'b0) begin
            n_bad++; $display("FAIL illegal_fallback: got done=%b col=%0d score=%0d to=%b nm=%b want 1 2 0 0 0",
                              bus.done, bus.col, bus.score, bus.timeout, bus.no_move);
        end
        n_cmp++;
        if (bus.me_field_out !== 42'h1FFF || bus.pile_count_array_out !== (pca | pca_one(2, 1))) begin
            n_bad++; $display("FAIL illegal_board: got me=%h pca=%h want 1fff %h",
                              bus.me_field_out, bus.pile_count_array_out, pca | pca_one(2, 1));
        end
    endtask

    task automatic test_reset_mid_search();
        bit ok;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rstmid_idle_wait: got busy want idle"); end
        start_turn('0, '0, '0);
        repeat (9) tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.search_en, bus.busy, bus.done, bus.timeout, bus.no_move} !== 5'b0) begin
            n_bad++; $display("FAIL rstmid_flags: got %b want 00000", {bus.search_en, bus.busy, bus.done, bus.timeout, bus.no_move});
        end
        n_cmp++;
        if ({bus.col, bus.me_field_out, bus.pile_count_array_out} !== '0) begin
            n_bad++; $display("FAIL rstmid_outputs: got col=%0d me=%h pca=%h want zeros",
                              bus.col, bus.me_field_out, bus.pile_count_array_out);
        end
        tick();
        rst     = 1'b0;
        bus.req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (bus.search_en !== 1'b0) begin
                n_bad++; $display("FAIL rstmid_cooldown_%0d: got en %b want 0", i, bus.search_en);
            end
        end
        bus.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus.search_en, bus.busy} !== 2'b00) begin
                n_bad++; $display("FAIL rstmid_ignored_%0d: got en/busy %b want 00", i, {bus.search_en, bus.busy});
            end
        end
        start_turn('0, '0, '0);
        n_cmp++;
        if (bus.search_en !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_relaunch: got en %b want 1", bus.search_en);
        end
        bus.search_fin = 1'b1; bus.search_col = 3'd6; bus.search_score = -16'sd1;
        tick();
        bus.search_fin = 1'b0;
        tick();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.col !== 3'd6 || bus.score !== -16'sd1 ||
            bus.me_field_out !== fbit(6, 0) || bus.pile_count_array_out !== pca_one(6, 1)) begin
            n_bad++; $display("FAIL rstmid_result: got done=%b col=%0d score=%0d pca=%h want 1 6 -1 %h",
                              bus.done, bus.col, bus.score, bus.pile_count_array_out, pca_one(6, 1));
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int dones = 0;
        int rises = 0;
        logic prev_en;
        logic seen = 1'b0;
        logic [COL_SIZE-1:0] got_col = '0;
        logic signed [15:0]  got_score = '0;
        logic [PCA_SIZE-1:0] got_pca = '0;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL b2b_idle_wait: got busy want idle"); end
        start_turn('0, '0, '0);
        bus.req = 1'b1;
        repeat (2) tick();
        bus.search_fin = 1'b1; bus.search_col = 3'd2; bus.search_score = 16'sd100;
        prev_en = bus.search_en;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 9) bus.search_fin = 1'b0;
            if (bus.search_en && !prev_en) rises++;
            prev_en = bus.search_en;
            if (bus.done) begin
                dones++;
                seen      = 1'b1;
                got_col   = bus.col;
                got_score = bus.score;
                got_pca   = bus.pile_count_array_out;
            end else if (seen) begin
                bus.req = 1'b0;
            end
        end
        n_cmp++;
        if (dones !== 1 || rises !== 0) begin
            n_bad++; $display("FAIL b2b_single_turn: got dones=%0d relaunches=%0d want 1 0", dones, rises);
        end
        n_cmp++;
        if (got_col !== 3'd2 || got_score !== 16'sd100 || got_pca !== pca_one(2, 1)) begin
            n_bad++; $display("FAIL b2b_result: got col=%0d score=%0d pca=%h want 2 100 %h",
                              got_col, got_score, got_pca, pca_one(2, 1));
        end
        n_cmp++;
        if ({bus.busy, bus.search_en} !== 2'b00) begin
            n_bad++; $display("FAIL b2b_final_idle: got busy/en %b want 00", {bus.busy, bus.search_en});
        end
    endtask

    initial begin
        bus.req              = 1'b0;
        bus.me_field         = '0;
        bus.op_field         = '0;
        bus.pile_count_array = '0;
        bus.search_fin       = 1'b0;
        bus.search_col       = '0;
        bus.search_score     = '0;
        test_reset();
        test_normal();
        test_timeout();
        test_fin_timeout_tie();
        test_no_move();
        test_illegal_col();
        test_reset_mid_search();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
